apb2axi_axi_slave_mem: RTL and testbench
========================================

// Module: apb2axi_axi_slave_mem
// PURPOSE
// AXI3 slave responder with internal word memory; the far end of the bridge's AXI master port.
// Accepts AW/W bursts and returns B; accepts AR and returns R beats after a programmable latency.
// Used as the bridge's system-level AXI target and as the reference slave for end-to-end APB->AXI->APB checks.
// One outstanding write and one outstanding read; the write and read paths are independent.
// PARAMETERS
// AXI_ADDR_W  32   address width
// AXI_DATA_W  32   data width; must be a power of 2 and >= 8
// AXI_ID_W    4    ID width
// MEM_DEPTH   256  memory depth in AXI_DATA_W words; power of 2
// RD_LAT      2    idle cycles between the AR handshake and the first rvalid (0 allowed)
// PORTS
// aclk     in   1             clock
// areset   in   1             synchronous reset, active-high
// awid     in   AXI_ID_W      write ID
// awaddr   in   AXI_ADDR_W    write start byte address
// awlen    in   4             beats-1
// awsize   in   3             log2 bytes per beat
// awburst  in   2             00 FIXED, 01 INCR, 10/11 unsupported
// awvalid  in   1             AW valid
// awready  out  1             AW ready
// wdata    in   AXI_DATA_W    write data
// wstrb    in   AXI_DATA_W/8  byte enables
// wlast    in   1             last write beat
// wvalid   in   1             W valid
// wready   out  1             W ready
// bid      out  AXI_ID_W      response ID (= latched awid)
// bresp    out  2             write response
// bvalid   out  1             B valid
// bready   in   1             B ready
// arid, araddr, arlen, arsize, arburst, arvalid  in  (same widths as AW)   read address channel
// arready  out  1             AR ready
// rid      out  AXI_ID_W      read ID (= latched arid)
// rdata    out  AXI_DATA_W    read data
// rresp    out  2             per-beat read response
// rlast    out  1             last read beat
// rvalid   out  1             R valid
// rready   in   1             R ready
// BEHAVIOUR
// - Reset: all outputs 0, both FSMs go to IDLE, memory cleared to 0. awready/arready rise the first cycle after areset falls.
// - A reset asserted mid-burst abandons the burst; no B or R is emitted for it.
// - Word index = addr[log2(BYTES)+log2(MEM_DEPTH)-1 : log2(BYTES)], where BYTES = AXI_DATA_W/8.
// - Error priority, latched at AW/AR handshake:
//   1. burst 10/11 or size != log2(BYTES) -> SLVERR (2'b10)
//   2. any address bit above the index nonzero, or INCR with start_idx+len > MEM_DEPTH-1 -> DECERR (2'b11)
//   3. otherwise OKAY (2'b00)
// - On error, writes are discarded and read data is 0. All len+1 beats are still transferred.
// - INCR: index +1 per beat. FIXED: index held constant.
// - Write FSM:
//   - W_IDLE (awready=1) -> W_DATA on awvalid&&awready; latches id, index, len, resp.
//   - W_DATA (wready=1): each wvalid&&wready writes the bytes selected by wstrb (when OKAY) and increments the beat counter.
//   - After beat len completes -> W_RESP.
//   - W_RESP (bvalid=1, bid/bresp stable) -> W_IDLE on bready.
//   - Burst termination counts beats and ignores wlast. wlast missing on the final beat, or asserted early, upgrades an OKAY bresp to SLVERR; writes already done are kept.
//   - W data presented before AW is stalled (wready=0 outside W_DATA).
// - Read FSM:
//   - R_IDLE (arready=1) -> R_WAIT when RD_LAT>0, else directly -> R_DATA.
//   - R_WAIT counts RD_LAT cycles, then -> R_DATA.
//   - R_DATA: rvalid=1; rdata = mem[idx] captured into a register; rlast=1 on beat==len.
//   - While rvalid&&!rready, rdata/rresp/rlast/rid are held stable.
//   - Each handshake advances one beat. The next beat's rvalid is asserted the following cycle, giving 1 beat/cycle at full throughput.
//   - The last handshake -> R_IDLE; arready returns the next cycle.
// - Simultaneous write and read to the same word: the read returns the pre-write value when both happen in the same cycle, and the new value from the next cycle on.
// - The beat counter is 4 bits and never wraps (max len 15). The INCR index never wraps, because of the DECERR check.
// TESTING
// - Single write: AW 0x10, len0, wdata 0xA5A5A5A5, strb 0xF -> bresp OKAY, bid=awid; then AR 0x10 -> rdata 0xA5A5A5A5, rlast=1.
// - INCR len3 write at 0x20 (data 1,2,3,4; strb on beat1 = 0x3 over old 0) -> readback 1, 0x00000002 masked to low 2 bytes, 3, 4; rvalid first asserts RD_LAT+1 cycles after AR.
// - rready toggled 1/0 every cycle during a len7 read -> 8 beats in order, rdata stable while stalled, rlast only on beat 8.
// - AW 0x400 (MEM_DEPTH=256, 32-bit data) -> DECERR, memory unchanged; AR with arburst=2'b10 -> 4 beats rresp SLVERR, rdata 0.
// - len3 write with wlast on beat 2 -> 4 beats accepted, bresp SLVERR.
// - areset asserted during R_DATA beat 2 of 4 -> rvalid 0 the next cycle; after release, arready=1 and no stale beats appear.

Source files
------------

// File: rtl/apb2axi_axi_slave_mem.sv
// apb2axi_axi_slave_mem
// AXI3 slave responder backed by an internal word memory. It is the far end of
// the bridge's AXI master port. One write and one read can be outstanding at a
// time, and the two paths are independent. Read data is returned after a
// programmable latency.
//
// Ports
//   aclk, areset                         clock, synchronous active-high reset
//   aw* / awready                        write address channel
//   w*  / wready                         write data channel
//   bid, bresp, bvalid / bready          write response channel
//   ar* / arready                        read address channel
//   rid, rdata, rresp, rlast, rvalid / rready   read data channel
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready=1, waiting for AW
//   W_DATA | wready=1, counting beats 0..len
//   W_RESP | bvalid=1, waiting for bready
//
// Read FSM
//   state  | meaning
//   R_IDLE | arready=1, waiting for AR
//   R_WAIT | latency countdown before the first beat
//   R_DATA | rvalid=1, registered beat presented, advance on rready
module apb2axi_axi_slave_mem #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 4,
    parameter int MEM_DEPTH  = 256,
    parameter int RD_LAT     = 2
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [AXI_ID_W-1:0]     awid,
    input  logic [AXI_ADDR_W-1:0]   awaddr,
    input  logic [3:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [AXI_DATA_W-1:0]   wdata,
    input  logic [AXI_DATA_W/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [AXI_ID_W-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [AXI_ID_W-1:0]     arid,
    input  logic [AXI_ADDR_W-1:0]   araddr,
    input  logic [3:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [AXI_ID_W-1:0]     rid,
    output logic [AXI_DATA_W-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int BYTES  = AXI_DATA_W / 8;
    localparam int OFF    = $clog2(BYTES);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int IDX_W1 = IDX_W + 1;
    localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = (RD_LAT > 0) ? LAT_W'(RD_LAT - 1) : '0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    // Burst/size errors take priority over decode errors.
    function automatic logic [1:0] check_resp(
        input logic [AXI_ADDR_W-1:0] addr,
        input logic [3:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [AXI_ADDR_W-1:0] hi;
        logic [IDX_W1-1:0]     end_idx;
        hi      = addr >> (OFF + IDX_W);
        end_idx = {1'b0, addr[OFF +: IDX_W]} + IDX_W1'(len);
        if (burst[1] || size != 3'(OFF))
            check_resp = RESP_SLVERR;
        else if (hi != '0 || (burst == 2'b01 && end_idx > IDX_W1'(MEM_DEPTH - 1)))
            check_resp = RESP_DECERR;
        else
            check_resp = RESP_OKAY;
    endfunction

    logic [AXI_DATA_W-1:0] mem [MEM_DEPTH];

    // Holds ready low for the first cycle after reset is released.
    logic run;

    w_state_t              w_state, w_next;
    logic                  aw_hs, w_hs;
    logic [AXI_ID_W-1:0]   w_id;
    logic [IDX_W-1:0]      w_idx;
    logic [3:0]            w_len, w_beat;
    logic [1:0]            w_resp;
    logic                  w_incr, w_lerr;

    r_state_t              r_state, r_next;
    logic                  ar_hs, r_hs, ld_en, ld_ok;
    logic [IDX_W-1:0]      ld_idx, ar_idx, r_idx;
    logic [AXI_ID_W-1:0]   r_id;
    logic [3:0]            r_len, r_beat;
    logic [1:0]            r_resp, ar_resp;
    logic                  r_incr;
    logic [LAT_W-1:0]      r_cnt;
    logic [AXI_DATA_W-1:0] rdata_q;

    // ---------------- write path ----------------
    always_ff @(posedge aclk) begin
        if (areset) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        aw_hs  = 1'b0;
        w_hs   = 1'b0;
        case (w_state)
            W_IDLE: if (awvalid && run) begin
                aw_hs  = 1'b1;
                w_next = W_DATA;
            end
            W_DATA: if (wvalid) begin
                w_hs = 1'b1;
                if (w_beat == w_len) w_next = W_RESP;
            end
            W_RESP: if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            run    <= 1'b0;
            w_id   <= '0;
            w_idx  <= '0;
            w_len  <= '0;
            w_beat <= '0;
            w_resp <= RESP_OKAY;
            w_incr <= 1'b0;
            w_lerr <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            run <= 1'b1;
            if (aw_hs) begin
                w_id   <= awid;
                w_idx  <= awaddr[OFF +: IDX_W];
                w_len  <= awlen;
                w_beat <= '0;
                w_resp <= check_resp(awaddr, awlen, awsize, awburst);
                w_incr <= (awburst == 2'b01);
                w_lerr <= 1'b0;
            end
            if (w_hs) begin
                if (w_resp == RESP_OKAY) begin
                    for (int b = 0; b < BYTES; b++)
                        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
                // Beat count ends the burst; wlast is only checked for consistency.
                if (wlast != (w_beat == w_len)) w_lerr <= 1'b1;
                w_beat <= w_beat + 1'b1;
                if (w_incr) w_idx <= w_idx + 1'b1;
            end
        end
    end

    assign awready = run && (w_state == W_IDLE);
    assign wready  = (w_state == W_DATA);
    assign bvalid  = (w_state == W_RESP);
    assign bid     = w_id;
    assign bresp   = (w_resp == RESP_OKAY && w_lerr) ? RESP_SLVERR : w_resp;

    // ---------------- read path ----------------
    assign ar_idx  = araddr[OFF +: IDX_W];
    assign ar_resp = check_resp(araddr, arlen, arsize, arburst);

    always_ff @(posedge aclk) begin
        if (areset) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // ld_en loads the beat register from mem[ld_idx]; the capture uses the
    // pre-write memory contents when a write lands in the same cycle.
    always_comb begin
        r_next = r_state;
        ar_hs  = 1'b0;
        r_hs   = 1'b0;
        ld_en  = 1'b0;
        ld_idx = r_idx;
        ld_ok  = (r_resp == RESP_OKAY);
        case (r_state)
            R_IDLE: if (arvalid && run) begin
                ar_hs = 1'b1;
                if (RD_LAT == 0) begin
                    r_next = R_DATA;
                    ld_en  = 1'b1;
                    ld_idx = ar_idx;
                    ld_ok  = (ar_resp == RESP_OKAY);
                end else begin
                    r_next = R_WAIT;
                end
            end
            R_WAIT: if (r_cnt == '0) begin
                r_next = R_DATA;
                ld_en  = 1'b1;
            end
            R_DATA: if (rready) begin
                r_hs = 1'b1;
                if (r_beat == r_len) begin
                    r_next = R_IDLE;
                end else begin
                    ld_en  = 1'b1;
                    ld_idx = r_incr ? r_idx + 1'b1 : r_idx;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_id    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_resp  <= RESP_OKAY;
            r_incr  <= 1'b0;
            r_cnt   <= '0;
            rdata_q <= '0;
        end else begin
            if (ar_hs) begin
                r_id   <= arid;
                r_idx  <= ar_idx;
                r_len  <= arlen;
                r_beat <= '0;
                r_resp <= ar_resp;
                r_incr <= (arburst == 2'b01);
                r_cnt  <= LAT_LOAD;
            end else if (r_state == R_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (r_hs) r_beat <= r_beat + 1'b1;
            if (ld_en) begin
                r_idx   <= ld_idx;
                rdata_q <= ld_ok ? mem[ld_idx] : '0;
            end
        end
    end

    assign arready = run && (r_state == R_IDLE);
    assign rvalid  = (r_state == R_DATA);
    assign rlast   = rvalid && (r_beat == r_len);
    assign rid     = r_id;
    assign rresp   = r_resp;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_apb2axi_axi_slave_mem.sv
// Directed bench for apb2axi_axi_slave_mem (32-bit data, 256 words, RD_LAT=2).
// Inputs are driven and outputs sampled on the falling edge of aclk.
module tb_apb2axi_axi_slave_mem;

    logic        aclk, areset;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int n_tests = 0;
    int n_fail  = 0;

    apb2axi_axi_slave_mem #(
        .AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_ID_W(4), .MEM_DEPTH(256), .RD_LAT(2)
    ) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_tests++;
        n_fail++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
        int t = 0;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        while (!awready && t < 20) begin @(negedge aclk); t++; end
        if (t >= 20) timeout("aw_wait");
        @(negedge aclk);
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic l);
        int t = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        while (!wready && t < 20) begin @(negedge aclk); t++; end
        if (t >= 20) timeout("w_wait");
        @(negedge aclk);
        wvalid = 1'b0;
    endtask

    task automatic get_b(input string tag, input logic [3:0] id, input logic [1:0] resp);
        int t = 0;
        bready = 1'b1;
        while (!bvalid && t < 20) begin @(negedge aclk); t++; end
        if (t >= 20) timeout({tag, "_wait"});
        chk({tag, "_bid"}, bid, id);
        chk({tag, "_bresp"}, bresp, resp);
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
        int t = 0;
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        while (!arready && t < 20) begin @(negedge aclk); t++; end
        if (t >= 20) timeout("ar_wait");
        @(negedge aclk);
        arvalid = 1'b0;
    endtask

    task automatic get_r(input string tag, input logic [3:0] id, input logic [31:0] d,
                         input logic [1:0] resp, input logic last);
        int t = 0;
        rready = 1'b1;
        while (!rvalid && t < 20) begin @(negedge aclk); t++; end
        if (t >= 20) timeout({tag, "_wait"});
        chk({tag, "_rdata"}, rdata, d);
        chk({tag, "_rresp"}, rresp, resp);
        chk({tag, "_rlast"}, rlast, last);
        chk({tag, "_rid"}, rid, id);
        @(negedge aclk);
    endtask

    initial begin
        int beat;
        areset = 1'b1;
        awid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = 2'b01; awvalid = 0;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = 2'b01; arvalid = 0;
        rready = 0;

        // Reset: everything quiet, ready one cycle after release.
        repeat (3) @(negedge aclk);
        chk("rst_awready", awready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_awready", awready, 1'b1);
        chk("post_rst_arready", arready, 1'b1);

        // Single write and readback.
        do_aw(4'd3, 32'h10, 4'd0, 2'b01);
        do_w(32'hA5A5_A5A5, 4'hF, 1'b1);
        get_b("single_b", 4'd3, 2'b00);
        do_ar(4'd5, 32'h10, 4'd0, 2'b01);
        get_r("single_r", 4'd5, 32'hA5A5_A5A5, 2'b00, 1'b1);
        rready = 1'b0;

        // INCR len3 with partial strobe on beat 1, then readback with latency check.
        do_aw(4'd7, 32'h20, 4'd3, 2'b01);
        do_w(32'h0000_0001, 4'hF, 1'b0);
        do_w(32'hBEEF_0002, 4'h3, 1'b0);
        do_w(32'h0000_0003, 4'hF, 1'b0);
        do_w(32'h0000_0004, 4'hF, 1'b1);
        get_b("incr_b", 4'd7, 2'b00);
        do_ar(4'd2, 32'h20, 4'd3, 2'b01);
        chk("lat_c1_rvalid", rvalid, 1'b0);
        @(negedge aclk);
        chk("lat_c2_rvalid", rvalid, 1'b0);
        @(negedge aclk);
        chk("lat_c3_rvalid", rvalid, 1'b1);
        get_r("incr_r0", 4'd2, 32'h0000_0001, 2'b00, 1'b0);
        get_r("incr_r1", 4'd2, 32'h0000_0002, 2'b00, 1'b0);
        get_r("incr_r2", 4'd2, 32'h0000_0003, 2'b00, 1'b0);
        get_r("incr_r3", 4'd2, 32'h0000_0004, 2'b00, 1'b1);
        rready = 1'b0;

        // len7 read with rready toggling every cycle.
        do_aw(4'd1, 32'h40, 4'd7, 2'b01);
        for (int i = 0; i < 8; i++) do_w(32'h100 + 32'(i), 4'hF, i == 7);
        get_b("l7_b", 4'd1, 2'b00);
        do_ar(4'd9, 32'h40, 4'd7, 2'b01);
        beat = 0;
        for (int c = 0; c < 60 && beat < 8; c++) begin
            rready = (c % 2 == 0);
            if (rvalid) begin
                chk($sformatf("l7_rdata_b%0d", beat), rdata, 32'h100 + 32'(beat));
                chk($sformatf("l7_rlast_b%0d", beat), rlast, beat == 7);
                if (rready) beat++;
            end
            @(negedge aclk);
        end
        if (beat < 8) timeout("l7_beats");
        rready = 1'b0;
        chk("l7_done_rvalid", rvalid, 1'b0);

        // Decode error on an out-of-range address; word 0 must stay 0.
        do_aw(4'd4, 32'h400, 4'd0, 2'b01);
        do_w(32'h1234_5678, 4'hF, 1'b1);
        get_b("decerr_b", 4'd4, 2'b11);
        do_ar(4'd4, 32'h0, 4'd0, 2'b01);
        get_r("decerr_mem0", 4'd4, 32'h0, 2'b00, 1'b1);
        rready = 1'b0;

        // INCR end-of-memory boundary: last word OK, one past it DECERR.
        do_aw(4'd6, 32'h3F8, 4'd1, 2'b01);
        do_w(32'h11, 4'hF, 1'b0);
        do_w(32'h22, 4'hF, 1'b1);
        get_b("edge_ok_b", 4'd6, 2'b00);
        do_aw(4'd6, 32'h3FC, 4'd1, 2'b01);
        do_w(32'h33, 4'hF, 1'b0);
        do_w(32'h44, 4'hF, 1'b1);
        get_b("edge_over_b", 4'd6, 2'b11);

        // Unsupported burst type on read: SLVERR beats with zero data.
        do_ar(4'd8, 32'h10, 4'd3, 2'b10);
        for (int i = 0; i < 4; i++)
            get_r($sformatf("slverr_r%0d", i), 4'd8, 32'h0, 2'b10, i == 3);
        rready = 1'b0;

        // Early wlast: all beats taken, response upgraded to SLVERR.
        do_aw(4'd10, 32'h80, 4'd3, 2'b01);
        do_w(32'hA, 4'hF, 1'b0);
        do_w(32'hB, 4'hF, 1'b1);
        do_w(32'hC, 4'hF, 1'b0);
        do_w(32'hD, 4'hF, 1'b0);
        get_b("wlast_b", 4'd10, 2'b10);

        // Reset during beat 2 of a 4-beat read.
        do_ar(4'd12, 32'h20, 4'd3, 2'b01);
        get_r("rst_mid_r0", 4'd12, 32'h0000_0001, 2'b00, 1'b0);
        rready = 1'b0;
        chk("rst_mid_beat2_valid", rvalid, 1'b1);
        areset = 1'b1;
        @(negedge aclk);
        chk("rst_mid_rvalid", rvalid, 1'b0);
        areset = 1'b0;
        rready = 1'b1;
        @(negedge aclk);
        chk("rst_mid_arready", arready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_mid_stale%0d", i), rvalid, 1'b0);
            @(negedge aclk);
        end
        rready = 1'b0;

        // Memory cleared by reset.
        do_ar(4'd13, 32'h10, 4'd0, 2'b01);
        get_r("rst_clear_r", 4'd13, 32'h0, 2'b00, 1'b1);
        rready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
